// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad serial configuration loader.
package gpio_cfg_pkg;

  localparam int GPIO_CFG_W = 13;
  localparam logic [GPIO_CFG_W-1:0] GPIO_CFG_DEFAULT = 13'h0402;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    FINISH
  } gpio_ldr_state_t;

endpackage

// File: rtl/gpio_serial_timer.sv
// Half-period counter: flags terminal count after CLK_DIV cycles of run,
// reloading on terminal count so each serial phase starts from zero.
module gpio_serial_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tc = run && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!run || tc)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Fetches one config word per pad and shifts the chain MSB-first, then loads it.
// Optional GPIO_SERIAL_AUTOLOAD_EN: self-start one sequence after reset release.
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_GPIO = 38,
  parameter int CLK_DIV  = 2,
  parameter int AW       = $clog2(NUM_GPIO)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_rd,
  output logic [AW-1:0]         cfg_addr,
  input  logic [GPIO_CFG_W-1:0] cfg_rdata,
  output logic                  serial_clock,
  output logic                  serial_load,
  output logic                  serial_data_out
);

  gpio_ldr_state_t state, next;

  logic [AW-1:0]         p;
  logic [3:0]            b;
  logic [GPIO_CFG_W-1:0] shreg;
  logic                  kick;
  logic                  run;
  logic                  tc;

`ifdef GPIO_SERIAL_AUTOLOAD_EN
  logic auto_pend;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      auto_pend <= 1'b1;
    else
      auto_pend <= 1'b0;
  end

  assign kick = start | auto_pend;
`else
  assign kick = start;
`endif

  assign run = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);

  gpio_serial_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .run (run),
    .tc  (tc)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= IDLE;
    else
      state <= next;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      p     <= '0;
      b     <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE:     if (kick) p <= AW'(NUM_GPIO - 1);
        WAIT: begin
          shreg <= cfg_rdata;
          b     <= 4'(GPIO_CFG_W - 1);
        end
        SHIFT_HI: if (tc) begin
          if (b != '0) begin
            shreg <= {shreg[GPIO_CFG_W-2:0], 1'b0};
            b     <= b - 1'b1;
          end else if (p != '0) begin
            p <= p - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data is only exposed in the shift states, so it can change only while the clock is low.
  always_comb begin
    next            = state;
    busy            = 1'b1;
    done            = 1'b0;
    cfg_rd          = 1'b0;
    serial_clock    = 1'b0;
    serial_load     = 1'b0;
    serial_data_out = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (kick) next = FETCH;
      end
      FETCH: begin
        cfg_rd = 1'b1;
        next   = WAIT;
      end
      WAIT: next = SHIFT_LO;
      SHIFT_LO: begin
        serial_data_out = shreg[GPIO_CFG_W-1];
        if (tc) next = SHIFT_HI;
      end
      SHIFT_HI: begin
        serial_clock    = 1'b1;
        serial_data_out = shreg[GPIO_CFG_W-1];
        if (tc) begin
          if (b != '0)      next = SHIFT_LO;
          else if (p != '0) next = FETCH;
          else              next = LOAD;
        end
      end
      LOAD: begin
        serial_load = 1'b1;
        if (tc) next = FINISH;
      end
      FINISH: begin
        busy = 1'b0;
        done = 1'b1;
        next = IDLE;
      end
      default: begin
        busy = 1'b0;
        next = IDLE;
      end
    endcase
  end

  assign cfg_addr = p;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: two instances (CLK_DIV=1 and 3), table-driven runs
// plus hand-written start-ignore and mid-shift reset sequences.
`timescale 1ns/1ps
module tb_gpio_serial_loader;
  import gpio_cfg_pkg::*;

  localparam int N   = 2;
  localparam int AWT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start = '0;
  logic [1:0] busy, done, cfg_rd, sclk, sload, sdo;
  logic [AWT-1:0] addr0, addr1;
  logic [12:0] rdata [2];
  logic [12:0] mem [2][N];

  gpio_serial_loader #(.NUM_GPIO(N), .CLK_DIV(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .cfg_rd(cfg_rd[0]), .cfg_addr(addr0), .cfg_rdata(rdata[0]),
    .serial_clock(sclk[0]), .serial_load(sload[0]), .serial_data_out(sdo[0]));

  gpio_serial_loader #(.NUM_GPIO(N), .CLK_DIV(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .cfg_rd(cfg_rd[1]), .cfg_addr(addr1), .cfg_rdata(rdata[1]),
    .serial_clock(sclk[1]), .serial_load(sload[1]), .serial_data_out(sdo[1]));

  // Config store: word valid one cycle after cfg_rd, junk otherwise.
  always @(posedge clk) begin
    rdata[0] <= cfg_rd[0] ? mem[0][addr0] : 13'($urandom);
    rdata[1] <= cfg_rd[1] ? mem[1][addr1] : 13'($urandom);
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int div(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int get_addr(input int i);
    return (i == 0) ? int'(addr0) : int'(addr1);
  endfunction

  bit q0[$], q1[$];
  int aq0[$], aq1[$];

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int aqsize(input int i);
    return (i == 0) ? aq0.size() : aq1.size();
  endfunction

  task automatic push_run(input int i);
    logic [12:0] w;
    for (int pd = N - 1; pd >= 0; pd--) begin
      w = mem[i][pd];
      if (i == 0) aq0.push_back(pd); else aq1.push_back(pd);
      for (int k = 12; k >= 0; k--)
        if (i == 0) q0.push_back(w[k]); else q1.push_back(w[k]);
    end
  endtask

  logic p_sclk [2];
  logic p_load [2];
  logic p_sdo  [2];
  int stab [2], hi_len [2], ld_len [2], rd_cnt [2], edges [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      p_sclk[i] = 0; p_load[i] = 0; p_sdo[i] = 0;
      stab[i] = 0; hi_len[i] = 0; ld_len[i] = 0; rd_cnt[i] = 0; edges[i] = 0;
    end
  end

  // Scoreboard monitor: sampled on the falling system-clock edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (i == 0) begin q0.delete(); aq0.delete(); end
        else        begin q1.delete(); aq1.delete(); end
        p_sclk[i] = 0; p_load[i] = 0; p_sdo[i] = 0;
        stab[i] = 0; hi_len[i] = 0; ld_len[i] = 0;
      end else begin
        bit eb;
        int ea;
        if (sclk[i] && !p_sclk[i]) begin
          edges[i]++;
          check($sformatf("setup%0d", i), int'(sdo[i] == p_sdo[i] && stab[i] >= div(i)), 1);
          check($sformatf("edge_expected%0d", i), int'(qsize(i) > 0), 1);
          if (qsize(i) > 0) begin
            eb = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("bit%0d_%0d", i, edges[i]), int'(sdo[i]), int'(eb));
          end
        end
        if (!sclk[i] && p_sclk[i])
          check($sformatf("hi_len%0d", i), hi_len[i], div(i));
        if (sload[i])
          check($sformatf("load_overlap%0d", i), int'(sclk[i]), 0);
        if (!sload[i] && p_load[i])
          check($sformatf("load_len%0d", i), ld_len[i], div(i));
        if (cfg_rd[i]) begin
          rd_cnt[i]++;
          check($sformatf("rd_expected%0d", i), int'(aqsize(i) > 0), 1);
          if (aqsize(i) > 0) begin
            ea = (i == 0) ? aq0.pop_front() : aq1.pop_front();
            check($sformatf("cfg_addr%0d", i), get_addr(i), ea);
          end
        end
        hi_len[i] = sclk[i]  ? (p_sclk[i] ? hi_len[i] + 1 : 1) : 0;
        ld_len[i] = sload[i] ? (p_load[i] ? ld_len[i] + 1 : 1) : 0;
        stab[i]   = (sdo[i] == p_sdo[i]) ? stab[i] + 1 : 1;
        p_sclk[i] = sclk[i];
        p_load[i] = sload[i];
        p_sdo[i]  = sdo[i];
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut1"}, int'({busy[0], done[0], cfg_rd[0], sclk[0], sload[0], sdo[0], addr0}), 0);
    check({tag, "_dut3"}, int'({busy[1], done[1], cfg_rd[1], sclk[1], sload[1], sdo[1], addr1}), 0);
  endtask

  task automatic release_reset();
    int n;
    @(negedge clk);
    rst = 1'b0;
`ifdef GPIO_SERIAL_AUTOLOAD_EN
    #1;
    push_run(0);
    push_run(1);
    n = 0;
    while (!(busy[0] && busy[1]) && n < 2) begin
      @(negedge clk); n++;
    end
    check("autoload_busy", int'(busy), 3);
    n = 0;
    while ((busy[0] || busy[1]) && n < 400) begin
      @(negedge clk); n++;
    end
    check("autoload_done", int'(busy), 0);
    check("autoload_stream", qsize(0) + qsize(1), 0);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic do_run(input int i, input int exp_lat, input int s2, input int s3, input bit fin);
    int n;
    bit got;
    push_run(i);
    rd_cnt[i] = 0;
    edges[i]  = 0;
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) check($sformatf("busy_rise%0d", i), int'(busy[i]), 1);
      if (done[i]) got = 1;
      else if (n == s2 || n == s3) begin
        start[i] = 1'b1;
        @(posedge clk);
        #1 start[i] = 1'b0;
      end
    end
    check($sformatf("done_latency%0d", i), n, exp_lat);
    check($sformatf("busy_at_done%0d", i), int'(busy[i]), 0);
    check($sformatf("rising_edges%0d", i), edges[i], 26);
    check($sformatf("cfg_rd_count%0d", i), rd_cnt[i], N);
    check($sformatf("stream_left%0d", i), qsize(i), 0);
    if (fin) begin
      start[i] = 1'b1;
      @(posedge clk);
      #1 start[i] = 1'b0;
      @(negedge clk);
      check($sformatf("finish_start_busy%0d", i), int'(busy[i]), 0);
      repeat (3) @(negedge clk);
      check($sformatf("finish_start_rd%0d", i), rd_cnt[i], N);
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int          sel;
    logic [12:0] w1;
    logic [12:0] w0;
    int          lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    vecs[0] = '{0, 13'h1803, GPIO_CFG_DEFAULT, 58};
    vecs[1] = '{1, 13'h1803, 13'h0402, 164};
    vecs[2] = '{0, 13'h1FFF, 13'h0000, 58};
    vecs[3] = '{1, 13'h0AAA, 13'h1555, 164};
    vecs[4] = '{0, 13'h1555, 13'h0AAA, 58};

    for (int i = 0; i < 2; i++) begin
      mem[i][1] = 13'h1803;
      mem[i][0] = 13'h0402;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    release_reset();

    for (int v = 0; v < 5; v++) begin
      mem[vecs[v].sel][1] = vecs[v].w1;
      mem[vecs[v].sel][0] = vecs[v].w0;
      do_run(vecs[v].sel, vecs[v].lat, 0, 0, 1'b0);
    end

    // Extra starts while busy and during FINISH must be ignored.
    mem[0][1] = 13'h0F0F;
    mem[0][0] = 13'h10F1;
    do_run(0, 58, 5, 20, 1'b1);

    // Reset while shifting pad 1 with the clock high, then a clean re-run.
    mem[0][1] = 13'h1803;
    mem[0][0] = 13'h0402;
    push_run(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    n = 0;
    while (!(n >= 8 && sclk[0]) && n < 500) begin
      @(negedge clk); n++;
    end
    check("reach_shift_hi", int'(sclk[0] && busy[0]), 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    release_reset();
    do_run(0, 58, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
